// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : timer_arbiter
// Purpose  : Round-robin sharing of one down-counting delay timer among
//            NUM_REQ requesters; pulses done to the owner at count expiry.
// Revision : 1.0 - initial release
// ============================================================================

module timer_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] cycles,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic                         busy
);

    localparam int unsigned C_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q,  state_d;
    logic [C_PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [C_PTR_W-1:0]   owner_q,  owner_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic [NUM_REQ-1:0]   grant_q,  grant_d;

    logic [CNT_WIDTH-1:0] w_cycles [NUM_REQ];
    logic                 w_found;
    logic [C_PTR_W-1:0]   w_winner;
    logic [C_PTR_W-1:0]   w_idx;
    int unsigned          w_sum;
    logic [CNT_WIDTH-1:0] w_cnt_load;
    logic [C_PTR_W-1:0]   w_owner_inc;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_cycles[gi] = cycles[gi*CNT_WIDTH +: CNT_WIDTH];
        end
    endgenerate

    // First set request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = 0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_sum = 32'(rr_ptr_q) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_idx = w_sum[C_PTR_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // A zero count behaves as one cycle, so the load value saturates at 0.
    assign w_cnt_load  = (w_cycles[w_winner] == '0) ? '0
                                                    : w_cycles[w_winner] - 1'b1;
    assign w_owner_inc = (owner_q == C_PTR_W'(NUM_REQ - 1)) ? '0
                                                            : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        count_d  = count_q;
        grant_d  = grant_q;
        done     = '0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (w_found) begin
                    state_d           = ST_RUN;
                    owner_d           = w_winner;
                    count_d           = w_cnt_load;
                    grant_d[w_winner] = 1'b1;
                end
            end
            ST_RUN: begin
                if (!req[owner_q]) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = w_owner_inc;
                end else if (count_q == '0) begin
                    done     = grant_q;
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = w_owner_inc;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            count_q  <= '0;
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            count_q  <= count_d;
            grant_q  <= grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_arbiter
// Purpose  : Directed and randomized checks of timer_arbiter against a
//            cycle-level behavioural model of the sharing rules.
// Revision : 1.0 - initial release
// ============================================================================

module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] cycles;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: whether the timer is owned, by whom, grant cycles remaining
    // (including the current one) and where the next search starts.
    bit m_busy;
    int m_owner;
    int m_rem;
    int m_ptr;

    logic [N-1:0] hist_g[$];
    logic [N-1:0] hist_d[$];
    logic [N-1:0] run_val[$];
    int           run_len[$];
    int           run_dn[$];
    bit           run_dlast[$];

    timer_arbiter #(
        .NUM_REQ   (N),
        .CNT_WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .cycles (cycles),
        .grant  (grant),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cyc_of(input int i);
        logic [N*W-1:0] c;
        c = cycles;
        return int'(c[i*W +: W]);
    endfunction

    task automatic set_cyc(input int i, input int v);
        cycles[i*W +: W] = W'(v);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_rem = 0; m_ptr = 0;
    endtask

    task automatic model_next();
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (req[i]) begin
                    m_busy  = 1'b1;
                    m_owner = i;
                    m_rem   = (cyc_of(i) == 0) ? 1 : cyc_of(i);
                    break;
                end
            end
        end else if (!req[m_owner] || m_rem == 1) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end else begin
            m_rem--;
        end
    endtask

    // One clock: compare outputs mid-cycle, advance model, return after edge.
    task automatic step();
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        @(negedge clk);
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        ed = (m_busy && req[m_owner] && m_rem == 1) ? eg : '0;
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("done",  32'(done),  32'(ed));
        check_eq("busy",  32'(busy),  32'(m_busy));
        hist_g.push_back(grant);
        hist_d.push_back(done);
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        hist_g.delete();
        hist_d.delete();
    endtask

    // Split the recorded grant trace into contiguous grant runs.
    task automatic analyze();
        run_val.delete(); run_len.delete(); run_dn.delete(); run_dlast.delete();
        for (int i = 0; i < hist_g.size(); i++) begin
            if (hist_g[i] != '0) begin
                if (i == 0 || hist_g[i-1] != hist_g[i]) begin
                    run_val.push_back(hist_g[i]);
                    run_len.push_back(0);
                    run_dn.push_back(0);
                    run_dlast.push_back(1'b0);
                end
                run_len[run_len.size()-1]++;
                if (hist_d[i] != '0) run_dn[run_dn.size()-1]++;
                if ((i + 1 == hist_g.size() || hist_g[i+1] != hist_g[i]) && hist_d[i] == hist_g[i])
                    run_dlast[run_dlast.size()-1] = 1'b1;
            end
        end
    endtask

    function automatic int total_done(input int upto);
        int n = 0;
        for (int i = 0; i < upto && i < hist_d.size(); i++)
            if (hist_d[i] != '0) n++;
        return n;
    endfunction

    initial begin
        logic [N-1:0] rr_exp [5];
        logic [N-1:0] wr_exp [3];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        wr_exp = '{4'b1000, 4'b0010, 4'b0100};

        rst = 1'b1; req = '0; cycles = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b0;
        step();

        // Single request, count 5
        clear_hist();
        req = 4'b0001; set_cyc(0, 5);
        repeat (6) step();
        req = '0;
        step();
        analyze();
        check_eq("single_pre",   32'(hist_g[0]), 32'h0);
        check_eq("single_runs",  run_val.size(), 1);
        if (run_val.size() >= 1) begin
            check_eq("single_val",  32'(run_val[0]), 32'h1);
            check_eq("single_len",  run_len[0], 5);
            check_eq("single_dn",   run_dn[0], 1);
            check_eq("single_last", 32'(run_dlast[0]), 32'h1);
        end
        check_eq("single_idle",  32'(hist_g[6]), 32'h0);

        // Zero count behaves as one cycle
        clear_hist();
        req = 4'b0100; set_cyc(2, 0);
        repeat (2) step();
        req = '0;
        step();
        check_eq("zero_grant", 32'(hist_g[1]), 32'h4);
        check_eq("zero_done",  32'(hist_d[1]), 32'h4);
        check_eq("zero_after", 32'(hist_g[2]), 32'h0);

        // Round-robin with all requesters active
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < N; i++) set_cyc(i, 3);
        clear_hist();
        req = 4'b1111;
        repeat (20) step();
        req = '0;
        step();
        analyze();
        check_eq("rr_runs", run_val.size(), 5);
        for (int k = 0; k < 5 && k < run_val.size(); k++) begin
            check_eq($sformatf("rr_val%0d", k),   32'(run_val[k]), 32'(rr_exp[k]));
            check_eq($sformatf("rr_len%0d", k),   run_len[k], 3);
            check_eq($sformatf("rr_dn%0d", k),    run_dn[k], 1);
            check_eq($sformatf("rr_last%0d", k),  32'(run_dlast[k]), 32'h1);
        end

        // Pointer wrap after requester 3, skipping idle requesters
        clear_hist();
        set_cyc(3, 2); set_cyc(1, 2); set_cyc(2, 2);
        req = 4'b1000;
        repeat (3) step();
        req = 4'b0110;
        repeat (6) step();
        req = '0;
        repeat (3) step();
        analyze();
        for (int k = 0; k < 3; k++) begin
            if (k < run_val.size()) check_eq($sformatf("wrap_val%0d", k), 32'(run_val[k]), 32'(wr_exp[k]));
            else                    check_eq($sformatf("wrap_missing%0d", k), 32'h0, 32'(wr_exp[k]));
        end

        // Abort in the 4th grant cycle of a 10-cycle count
        clear_hist();
        set_cyc(0, 10); set_cyc(1, 3);
        req = 4'b0001;
        repeat (4) step();
        req = '0;
        step();
        req = 4'b0011;
        repeat (2) step();
        req = '0;
        repeat (3) step();
        check_eq("abort_held",  32'(hist_g[4]), 32'h1);
        check_eq("abort_nodn",  total_done(6), 0);
        check_eq("abort_drop",  32'(hist_g[5]), 32'h0);
        check_eq("abort_next",  32'(hist_g[6]), 32'h2);

        // Reset in the 2nd cycle of an 8-cycle grant
        clear_hist();
        set_cyc(2, 8); set_cyc(0, 2); set_cyc(3, 2);
        req = 4'b0100;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1001;
        repeat (2) step();
        req = '0;
        repeat (3) step();
        check_eq("rstmid_before", 32'(hist_g[2]), 32'h4);
        check_eq("rstmid_grant",  32'(hist_g[3]), 32'h0);
        check_eq("rstmid_done",   32'(hist_d[3]), 32'h0);
        check_eq("rstmid_ptr",    32'(hist_g[4]), 32'h1);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            if ($urandom_range(0, 3) == 0) set_cyc($urandom_range(0, N-1), $urandom_range(0, 6));
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
